// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and the fetch-queue entry layout.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef struct packed {
    word_t instr;
    word_t pc;
    word_t npc;
  } ifq_entry_t;

endpackage

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: decouples I-memory hits from decode with a DEPTH-entry
// circular buffer; one-cycle capture latency, flush and reset empty the queue.
module ifetch_queue
  import cpu_types_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  word_t                      imemaddr,
  input  word_t                      nPC,
  input  logic                       ihit,
  input  word_t                      imemload,
  output logic                       imemREN,
  output logic                       pcen,
  input  logic                       flush,
  input  logic                       id_ready,
  output logic                       id_valid,
  output word_t                      id_instr,
  output word_t                      id_pc,
  output word_t                      id_npc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  ifq_entry_t        entries [DEPTH];
  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic              full;
  logic              empty;
  logic              enq;
  logic              deq;
  ifq_entry_t        head_entry;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Full blocks enqueue even when decode drains the head the same cycle.
  assign enq      = ihit & ~full & ~flush;
  assign deq      = id_valid & id_ready & ~flush;
  assign imemREN  = ~full & ~flush;
  assign pcen     = enq;
  assign id_valid = ~empty;

  assign head_entry = entries[head];
  assign id_instr   = empty ? '0 : head_entry.instr;
  assign id_pc      = empty ? '0 : head_entry.pc;
  assign id_npc     = empty ? '0 : head_entry.npc;

  always_ff @(posedge CLK) begin
    if (RST || flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + PW'(1);
      if (deq) head <= head + PW'(1);
      case ({enq, deq})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is never cleared; the pointers and count decide what is live.
  always_ff @(posedge CLK) begin
    if (enq) begin
      entries[tail] <= '{instr: imemload, pc: imemaddr, npc: nPC};
    end
  end

endmodule
